// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit barrel shifter among NREQ requesters.
// The result is registered with the winner's ID and held under valid/ready backpressure.

module shifter (
  input  logic [15:0] din,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic [15:0] dout
);
  logic [31:0] dbl_l;
  logic [31:0] dbl_r;

  // A rotate is a shift of the operand concatenated with itself.
  always_comb begin
    dbl_l = {din, din} << cnt;
    dbl_r = {din, din} >> cnt;
    case (op)
      2'b00:   dout = dbl_l[31:16];
      2'b01:   dout = din << cnt;
      2'b10:   dout = dbl_r[15:0];
      default: dout = din >> cnt;
    endcase
  end
endmodule

// Handshake: a request is taken when req_valid[i] & req_ready[i]; the result is
// taken when rsp_valid & rsp_ready. A full slot may be refilled in the cycle it drains.
module shift_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_in,
  input  logic [4*NREQ-1:0]    req_cnt,
  input  logic [2*NREQ-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [1:0]           rsp_id,
  output logic [15:0]          op_count
);
  generate
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("shift_arbiter: NREQ must be in 2..4");
    end
  endgenerate

  logic [1:0]  last_ptr;
  logic [3:0]  valid4;
  logic [3:0]  grant4;
  logic [1:0]  gidx;
  logic        gany;
  logic [1:0]  idx;
  logic        slot_free;
  logic        accept;
  logic [15:0] sel_in;
  logic [3:0]  sel_cnt;
  logic [1:0]  sel_op;
  logic [15:0] sh_out;

  assign valid4    = 4'(req_valid);
  assign slot_free = ~rsp_valid | rsp_ready;
  assign accept    = gany & slot_free;
  assign req_ready = grant4[NREQ-1:0] & {NREQ{slot_free}};

  // Search begins just after the last winner; reset also suppresses the grant.
  always_comb begin
    grant4 = 4'b0000;
    gidx   = 2'd0;
    gany   = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 2'((32'(last_ptr) + 32'(k)) % NREQ);
      if (!gany && valid4[idx] && rst_n) begin
        gany        = 1'b1;
        gidx        = idx;
        grant4[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_in  = 16'h0000;
    sel_cnt = 4'h0;
    sel_op  = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant4[i]) begin
        sel_in  = req_in[16*i +: 16];
        sel_cnt = req_cnt[4*i +: 4];
        sel_op  = req_op[2*i +: 2];
      end
    end
  end

  shifter u_shifter (
    .din  (sel_in),
    .cnt  (sel_cnt),
    .op   (sel_op),
    .dout (sh_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_id    <= 2'd0;
      op_count  <= 16'h0000;
      last_ptr  <= 2'(NREQ - 1);
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sh_out;
      rsp_id    <= gidx;
      last_ptr  <= gidx;
      op_count  <= op_count + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Randomised and directed bench for shift_arbiter (NREQ=4) with a queue scoreboard
// fed by a behavioural reference model.

module tb_shift_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_in = '0;
  logic [4*N-1:0]  req_cnt = '0;
  logic [2*N-1:0]  req_op = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [15:0]   rsp_data;
  logic [1:0]    rsp_id;
  logic [15:0]   op_count;

  always #5 clk = ~clk;

  shift_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .req_cnt   (req_cnt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [17:0] exp_q[$];

  // Reference model state: what the DUT should hold right now.
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_count;

  // Pending request per requester, held until accepted.
  logic        pv[N];
  logic [15:0] pin[N];
  logic [3:0]  pcnt[N];
  logic [1:0]  pop[N];

  logic        use_tab = 1'b0;
  logic [15:0] tab_exp = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] x_in, input logic [3:0] c, input logic [1:0] o);
    logic [15:0] x;
    x = x_in;
    for (int k = 0; k < int'(c); k++) begin
      case (o)
        2'd0: x = {x[14:0], x[15]};
        2'd1: x = {x[14:0], 1'b0};
        2'd2: x = {x[0], x[15:1]};
        default: x = {1'b0, x[15:1]};
      endcase
    end
    return x;
  endfunction

  task automatic set_req(input int i, input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
    pv[i] = 1'b1;
    pin[i] = d;
    pcnt[i] = c;
    pop[i] = o;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
  endtask

  // One clock cycle: drive, predict, score.
  task automatic step(input logic rr, input logic chk, input logic [3:0] want);
    logic free;
    int g;
    int idx;
    logic [3:0] exp_rdy;
    logic [15:0] res;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pv[i];
      req_in[16*i +: 16] = pin[i];
      req_cnt[4*i +: 4] = pcnt[i];
      req_op[2*i +: 2] = pop[i];
    end
    rsp_ready = rr;
    #1;
    free = !m_valid || rr;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && pv[idx]) g = idx;
    end
    exp_rdy = (free && g >= 0) ? 4'(1 << g) : 4'b0000;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (chk) check("grant_seq", 32'(req_ready), 32'(want));
    if (free && g >= 0) begin
      res = use_tab ? tab_exp : ref_shift(pin[g], pcnt[g], pop[g]);
      exp_q.push_back({2'(g), res});
      m_ptr = g;
      m_count = m_count + 16'd1;
      m_valid = 1'b1;
      pv[g] = 1'b0;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("op_count", 32'(op_count), 32'(m_count));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 4'hF;
    rst_n = 1'b0;
    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_op_count", 32'(op_count), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    m_ptr = N - 1;
    m_valid = 1'b0;
    m_count = 16'h0000;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pops on every consumer handshake, and checks the hold during backpressure.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = 16'h0;
  logic [1:0]  prev_id = 2'd0;
  always begin
    logic [17:0] e;
    @(negedge clk);
    #3;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_data", 32'(rsp_data), 32'(prev_data));
        check("hold_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
          check("rsp_id", 32'(rsp_id), 32'(e[17:16]));
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      prev_id = rsp_id;
    end
  end

  logic [15:0] tab_in [4] = '{16'h1234, 16'h8001, 16'h0001, 16'h8000};
  logic [3:0]  tab_cnt[4] = '{4'd4, 4'd1, 4'd1, 4'd15};
  logic [15:0] tab_out[4] = '{16'h2341, 16'h0002, 16'h8000, 16'h0001};

  initial begin
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pin[i] = 16'h0; pcnt[i] = 4'h0; pop[i] = 2'b00;
    end
    m_ptr = N - 1;
    m_valid = 1'b0;
    m_count = 16'h0000;

    do_reset();

    // Directed ops on requester 0 with known answers.
    use_tab = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(0, tab_in[t], tab_cnt[t], 2'(t));
      tab_exp = tab_out[t];
      step(1'b1, 1'b1, 4'b0001);
    end
    use_tab = 1'b0;
    step(1'b1, 1'b1, 4'b0000);
    check("op_count_four", 32'(op_count), 32'd4);

    // Two requesters continuously valid alternate from reset.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      if (!pv[0]) rand_req(0);
      if (!pv[1]) rand_req(1);
      step(1'b1, 1'b1, (t % 2 == 0) ? 4'b0001 : 4'b0010);
    end

    // Backpressure: result pending, consumer stalls three cycles.
    for (int t = 0; t < 3; t++) begin
      if (!pv[0]) rand_req(0);
      if (!pv[1]) rand_req(1);
      step(1'b0, 1'b1, 4'b0000);
    end
    step(1'b1, 1'b1, 4'b0001);
    check("refill_valid", 32'(rsp_valid), 32'd1);

    // Sparse requesters 1 and 3, with an idle cycle in between.
    do_reset();
    pv[1] = 1'b0; pv[0] = 1'b0; pv[2] = 1'b0;
    rand_req(3);
    step(1'b1, 1'b1, 4'b1000);
    rand_req(1); rand_req(3);
    step(1'b1, 1'b1, 4'b0010);
    pv[3] = 1'b0;
    step(1'b1, 1'b1, 4'b0000);
    rand_req(1); rand_req(3);
    step(1'b1, 1'b1, 4'b1000);
    step(1'b1, 1'b1, 4'b0010);

    // Count zero is a pass-through for every op.
    use_tab = 1'b1;
    tab_exp = 16'hA5C3;
    for (int o = 0; o < 4; o++) begin
      set_req(0, 16'hA5C3, 4'd0, 2'(o));
      step(1'b1, 1'b0, 4'b0000);
    end
    use_tab = 1'b0;

    // Random traffic with random consumer stalls.
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 2) != 0) rand_req(i);
      step(($urandom_range(0, 3) != 0), 1'b0, 4'b0000);
    end

    // Asynchronous reset while a result is pending.
    rand_req(0);
    step(1'b0, 1'b0, 4'b0000);
    check("pending_before_rst", 32'(rsp_valid), 32'd1);
    do_reset();
    rand_req(1); rand_req(0);
    step(1'b1, 1'b1, 4'b0001);

    // op_count wraps after 65536 accepts.
    do_reset();
    for (int t = 0; t < 65536; t++) begin
      if (!pv[0]) rand_req(0);
      step(1'b1, 1'b0, 4'b0000);
    end
    check("op_count_wrap", 32'(op_count), 32'h0);

    step(1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0000);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
